// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
package ripple_carry_adder_pkg;

    localparam int ADDER_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full adder cell; chained by the top level to form the ripple carry path.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Registered ripple-carry adder: {cout, s} = a + b + cin with signed overflow flag,
// one-cycle latency, outputs held while in_valid is low.
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;
    logic             ovf_next;

    assign c[0] = cin;

    // Carry ripples bit-serially through the chain: c[i+1] comes from cell i.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    assign ovf_next = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s    <= sum;
                cout <= c[WIDTH];
                ovf  <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed and sweep checks of ripple_carry_adder at WIDTH 4, 1 and 16.
module tb_ripple_carry_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        in_valid4 = 1'b0, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [3:0]  s4;
    logic        cout4, ovf4, out_valid4;

    logic        in_valid1 = 1'b0, cin1 = 1'b0;
    logic [0:0]  a1 = '0, b1 = '0;
    logic [0:0]  s1;
    logic        cout1, ovf1, out_valid1;

    logic        in_valid16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [15:0] s16;
    logic        cout16, ovf16, out_valid16;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ripple_carry_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .a(a4), .b(b4), .cin(cin4),
        .s(s4), .cout(cout4), .ovf(ovf4), .out_valid(out_valid4)
    );

    ripple_carry_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .a(a1), .b(b1), .cin(cin1),
        .s(s1), .cout(cout1), .ovf(ovf1), .out_valid(out_valid1)
    );

    ripple_carry_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .a(a16), .b(b16), .cin(cin16),
        .s(s16), .cout(cout16), .ovf(ovf16), .out_valid(out_valid16)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkW4(input string tag, input logic [3:0] exp_s, input logic exp_cout,
                           input logic exp_ovf, input logic exp_valid);
        checkOutput({tag, ".s"}, 64'(s4), 64'(exp_s));
        checkOutput({tag, ".cout"}, 64'(cout4), 64'(exp_cout));
        checkOutput({tag, ".ovf"}, 64'(ovf4), 64'(exp_ovf));
        checkOutput({tag, ".out_valid"}, 64'(out_valid4), 64'(exp_valid));
    endtask

    // Drive the WIDTH=4 instance at the falling edge, then sample 1 time unit after the capture edge.
    task automatic applyStimulus(input logic valid, input logic [3:0] a, input logic [3:0] b,
                                 input logic cin);
        @(negedge clk);
        in_valid4 = valid;
        a4        = a;
        b4        = b;
        cin4      = cin;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] refSum(input longint unsigned a, input longint unsigned b,
                                           input logic cin, input int w);
        longint unsigned mask;
        mask = (longint'(1) << (w + 1)) - 1;
        return (a + b + longint'(cin)) & mask;
    endfunction

    function automatic logic refOvf(input longint unsigned a, input longint unsigned b,
                                    input logic cin, input int w);
        longint sa, sb, total, hi, lo;
        sa    = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb    = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        total = sa + sb + longint'(cin);
        hi    = (longint'(1) << (w - 1)) - 1;
        lo    = -(longint'(1) << (w - 1));
        return (total > hi) || (total < lo);
    endfunction

    logic [63:0] exp4, exp1, exp16;
    logic        eovf4, eovf1, eovf16;

    task automatic checkSweep();
        checkOutput("sw4.s", 64'(s4), 64'(exp4[3:0]));
        checkOutput("sw4.cout", 64'(cout4), 64'(exp4[4]));
        checkOutput("sw4.ovf", 64'(ovf4), 64'(eovf4));
        checkOutput("sw4.out_valid", 64'(out_valid4), 64'd1);
        checkOutput("sw1.s", 64'(s1), 64'(exp1[0]));
        checkOutput("sw1.cout", 64'(cout1), 64'(exp1[1]));
        checkOutput("sw1.ovf", 64'(ovf1), 64'(eovf1));
        checkOutput("sw16.s", 64'(s16), 64'(exp16[15:0]));
        checkOutput("sw16.cout", 64'(cout16), 64'(exp16[16]));
        checkOutput("sw16.ovf", 64'(ovf16), 64'(eovf16));
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        checkW4("rst_async", 4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkW4("rst_hold", 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("rst.w1.out_valid", 64'(out_valid1), 64'd0);
        checkOutput("rst.w16.s", 64'(s16), 64'd0);

        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b1, 4'b1011, 4'b1111, 1'b0);
        checkW4("v1011_1111", 4'b1010, 1'b1, 1'b0, 1'b1);

        applyStimulus(1'b0, 4'b0000, 4'b0101, 1'b0);
        checkW4("hold", 4'b1010, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
        checkW4("hold_x", 4'b1010, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, 4'b0111, 4'b0001, 1'b0);
        checkW4("pos_ovf", 4'b1000, 1'b0, 1'b1, 1'b1);

        applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1);
        checkW4("wrap_f_0_1", 4'b0000, 1'b1, 1'b0, 1'b1);

        applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1);
        checkW4("wrap_f_f_1", 4'b1111, 1'b1, 1'b0, 1'b1);

        // Reset mid-cycle while a valid result is showing: outputs must clear before the next edge.
        #3 rst = 1'b1;
        #1;
        checkW4("rst_mid", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkW4("rst_mid_edge", 4'b0000, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        in_valid4 = 1'b1;
        a4 = 4'b0011;
        b4 = 4'b0100;
        cin4 = 1'b1;
        @(posedge clk);
        #1;
        checkW4("post_rst", 4'b1000, 1'b0, 1'b1, 1'b1);

        // Back-to-back sweep: exhaustive at WIDTH=4, random at WIDTH=1 and WIDTH=16.
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (i > 0) checkSweep();
            in_valid4  = 1'b1;
            a4         = 4'(i >> 5);
            b4         = 4'(i >> 1);
            cin4       = i[0];
            in_valid1  = 1'b1;
            a1         = 1'($urandom);
            b1         = 1'($urandom);
            cin1       = 1'($urandom);
            in_valid16 = 1'b1;
            a16        = 16'($urandom);
            b16        = 16'($urandom);
            cin16      = 1'($urandom);
            exp4   = refSum(64'(a4), 64'(b4), cin4, 4);
            eovf4  = refOvf(64'(a4), 64'(b4), cin4, 4);
            exp1   = refSum(64'(a1), 64'(b1), cin1, 1);
            eovf1  = refOvf(64'(a1), 64'(b1), cin1, 1);
            exp16  = refSum(64'(a16), 64'(b16), cin16, 16);
            eovf16 = refOvf(64'(a16), 64'(b16), cin16, 16);
        end
        @(negedge clk);
        checkSweep();
        in_valid4  = 1'b0;
        in_valid1  = 1'b0;
        in_valid16 = 1'b0;
        a4  = 4'b0101;
        a16 = 16'h1234;
        @(negedge clk);
        checkOutput("end.w4.out_valid", 64'(out_valid4), 64'd0);
        checkOutput("end.w4.s", 64'(s4), 64'(exp4[3:0]));
        checkOutput("end.w16.out_valid", 64'(out_valid16), 64'd0);
        checkOutput("end.w16.s", 64'(s16), 64'(exp16[15:0]));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ripple_carry_adder.md
Name: ripple_carry_adder

Overview:
- Parameterised ripple-carry adder: computes a + b + cin through a chain of 1-bit full adders.
- Registers the sum, carry-out and signed-overflow flag on the clock edge, with a valid qualifier.
- Used as a registered arithmetic leaf in datapaths: one input beat per cycle, fixed one-cycle latency, no backpressure.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1 to 64).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a, b and cin in the current cycle.
- a  input  WIDTH  operand A, unsigned (or two's complement for ovf).
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- s  output  WIDTH  registered sum bits [WIDTH-1:0].
- cout  output  1  registered carry out of the MSB.
- ovf  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Combinational core:
  - c[0] = cin.
  - For each bit i: sum[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])).
  - The carry must ripple bit-serially; no lookahead or prefix logic.
- Full result {cout, s} equals a + b + cin, computed at WIDTH+1 bits with no truncation.
- ovf = c[WIDTH] ^ c[WIDTH-1]. For WIDTH = 1, c[0] is cin.
- Reset:
  - While rst = 1, s = 0, cout = 0, ovf = 0, out_valid = 0, immediately and without waiting for a clock edge.
  - Reset asserted mid-operation discards any pending result.
  - The first capture after release occurs on the first rising edge with rst = 0.
- Capture, on rising clk with rst = 0:
  - out_valid <= in_valid.
  - If in_valid = 1: s, cout and ovf load the combinational result.
  - If in_valid = 0: s, cout and ovf hold their previous values.
- Latency: exactly one cycle from the input sample edge to the registered output. Throughput is one result per cycle.
- X or unqualified inputs while in_valid = 0 must not disturb the held outputs.
- Wrap-around:
  - All-ones + all-ones + 1 gives s = all-ones, cout = 1.
  - All-ones + 0 + 1 gives s = 0, cout = 1.
- No internal state other than the output registers.

Decomposition:
- Shared package: the default WIDTH constant (ADDER_WIDTH_DEFAULT = 4). No typedefs required.
- One sub-module, full_adder (a, b, cin -> s, cout, purely combinational), instantiated WIDTH times via generate to form the ripple chain.
- The top level holds the carry vector, the overflow derivation and the output registers.

Test Plan:
- WIDTH=4, rst pulse, then in_valid=1, a=1011, b=1111, cin=0 -> next edge s=1010, cout=1, ovf=0, out_valid=1.
- a=0111, b=0001, cin=0 -> s=1000, cout=0, ovf=1 (signed +7 + +1 overflow).
- a=1111, b=0000, cin=1 -> s=0000, cout=1, ovf=0. Then a=1111, b=1111, cin=1 -> s=1111, cout=1, ovf=0.
- After a valid result s=1010, drive in_valid=0 with a=0000, b=0101 -> out_valid=0 and s/cout/ovf hold 1010/1/0.
- Assert rst asynchronously between edges while out_valid=1 -> all outputs 0 before the next edge. Release rst with in_valid=1, a=0011, b=0100, cin=1 -> s=1000, cout=0, ovf=1 one edge later.
- Exhaustive WIDTH=4 sweep of all a, b, cin (512 cases), back-to-back with in_valid=1 -> each result matches a+b+cin and the signed-overflow reference with one-cycle latency. Repeat a random sweep at WIDTH=1 and WIDTH=16.
